cond_exec_unit: RTL

COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

---
 rtl/cond_exec_unit.sv | 101 ++++++++++
 1 files changed

// File: rtl/cond_exec_unit.sv
// Conditional-execution stage: evaluates the ARM condition against the architectural flags and gates the EX controls into MEM.
// The gate is combinational and the M controls, flags and counter update one cycle later. Stall freezes all state.
module cond_exec_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic        FlushE,
   input  logic        ValidE,
   input  logic [3:0]  CondE,
   input  logic [3:0]  ALUFlags,
   input  logic [1:0]  FlagWriteE,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic        MemtoRegE,
   input  logic        PCSrcE,
   output logic [3:0]  Flags,
   output logic        CondExE,
   output logic        BranchTakenE,
   output logic        RegWriteM,
   output logic        MemWriteM,
   output logic        MemtoRegM,
   output logic        PCSrcM,
   output logic [15:0] SquashCount
);

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
      COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
      COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
      COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
   } cond_e;

   logic [3:0]  flags_q, flags_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [15:0] cnt_q, cnt_d;

   logic flag_n, flag_z, flag_c, flag_v;
   logic go, squash;
   cond_e cond;

   assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
   assign cond = cond_e'(CondE);

   // Condition uses the registered flags only, so a same-cycle flag write is not seen.
   always_comb begin
      CondExE = 1'b0;
      unique case (cond)
         COND_EQ: CondExE = flag_z;
         COND_NE: CondExE = ~flag_z;
         COND_CS: CondExE = flag_c;
         COND_CC: CondExE = ~flag_c;
         COND_MI: CondExE = flag_n;
         COND_PL: CondExE = ~flag_n;
         COND_VS: CondExE = flag_v;
         COND_VC: CondExE = ~flag_v;
         COND_HI: CondExE = flag_c & ~flag_z;
         COND_LS: CondExE = ~(flag_c & ~flag_z);
         COND_GE: CondExE = (flag_n == flag_v);
         COND_LT: CondExE = (flag_n != flag_v);
         COND_GT: CondExE = ~flag_z & (flag_n == flag_v);
         COND_LE: CondExE = ~(~flag_z & (flag_n == flag_v));
         COND_AL: CondExE = 1'b1;
         COND_NV: CondExE = 1'b0;
         default: CondExE = 1'b0;
      endcase
   end

   assign go           = CondExE & ValidE & ~FlushE;
   assign squash       = ValidE & ~FlushE & ~CondExE;
   assign BranchTakenE = PCSrcE & go;

   always_comb begin
      flags_d = flags_q;
      if (FlagWriteE[1] && go) flags_d[3:2] = ALUFlags[3:2];
      if (FlagWriteE[0] && go) flags_d[1:0] = ALUFlags[1:0];
      // A flushed or failed instruction becomes a bubble.
      ctrl_d = {RegWriteE, MemWriteE, MemtoRegE, PCSrcE} & {4{go}};
      cnt_d  = cnt_q;
      if (squash && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= 4'b0000;
         ctrl_q  <= 4'b0000;
         cnt_q   <= 16'h0000;
      end else if (!Stall) begin
         flags_q <= flags_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Flags       = flags_q;
   assign RegWriteM   = ctrl_q[3];
   assign MemWriteM   = ctrl_q[2];
   assign MemtoRegM   = ctrl_q[1];
   assign PCSrcM      = ctrl_q[0];
   assign SquashCount = cnt_q;

endmodule
